// File: rtl/spi_pkg.sv
// Shared definitions for the SPI initiator and the slave-side wrapper:
// command encodings, frame geometry and the initiator state encoding.
package spi_pkg;

    // Two-bit command field sent ahead of every payload byte.
    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    // Outgoing frame is {cmd, payload}; the reply is one byte.
    localparam int FRAME_LEN = 10;
    localparam int RX_LEN    = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        SHIFT,
        WAIT_RD,
        READ,
        GAP
    } spi_state_t;

    // Only the read-data command makes the slave answer on MISO.
    function automatic logic expects_reply(input logic [1:0] c);
        return c == CMD_RD_DATA;
    endfunction

endpackage

// File: rtl/spi_master.sv
// Host-side SPI initiator. Accepts {cmd, cmd_data} over valid/ready,
// shifts the 10-bit frame out MSB first under SS_n and, for read-data
// commands, collects the 8-bit reply from MISO. SCK is clk itself.
//
// MOSI and SS_n are registered: the value seen after an edge is the one
// chosen for the state that was current at that edge. The serial line
// therefore lags the state register by one cycle, which is why the last
// frame bit is still on the wire during the first cycle of the following
// state, and why SS_n rises on the first GAP edge rather than on entry.
module spi_master
    import spi_pkg::*;
#(
    parameter int unsigned RD_WAIT    = 1,
    parameter int unsigned GAP_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd,
    input  logic [7:0] cmd_data,
    output logic       rd_valid,
    output logic [7:0] rd_data,
    output logic       busy,
    output logic       MOSI,
    output logic       SS_n,
    input  logic       MISO
);

    // Terminal counts for each timed state; the counter is shared.
    localparam logic [3:0] SHIFT_LAST = 4'(FRAME_LEN - 1);
    localparam logic [3:0] READ_LAST  = 4'(RX_LEN - 1);
    localparam logic [3:0] WAIT_LAST  = (RD_WAIT > 0) ? 4'(RD_WAIT - 1) : 4'd0;
    localparam logic [3:0] GAP_LAST   = 4'(GAP_CYCLES - 1);

    spi_state_t state_reg, state_next;
    logic [3:0] cnt_reg, cnt_next;

    logic [FRAME_LEN-1:0] tx_shift_reg;
    logic [RX_LEN-1:0]    rx_shift_reg;
    logic                 rd_frame_reg;
    logic                 mosi_reg;
    logic                 ss_n_reg;
    logic                 rd_valid_reg;
    logic [7:0]           rd_data_reg;

    logic accept;

    assign cmd_ready = (state_reg == IDLE);
    assign busy      = (state_reg != IDLE);
    assign accept    = cmd_valid && cmd_ready;

    assign MOSI      = mosi_reg;
    assign SS_n      = ss_n_reg;
    assign rd_valid  = rd_valid_reg;
    assign rd_data   = rd_data_reg;

    // State and shared cycle counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= 4'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Next-state sequencing: fixed-length SHIFT, optional turnaround,
    // 8-bit READ for read-data frames, then a deselect gap.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        unique case (state_reg)
            IDLE: begin
                cnt_next = 4'd0;
                if (accept) begin
                    state_next = START;
                end
            end
            START: begin
                state_next = SHIFT;
                cnt_next   = 4'd0;
            end
            SHIFT: begin
                if (cnt_reg == SHIFT_LAST) begin
                    cnt_next = 4'd0;
                    if (rd_frame_reg) begin
                        state_next = (RD_WAIT > 0) ? WAIT_RD : READ;
                    end else begin
                        state_next = GAP;
                    end
                end else begin
                    cnt_next = cnt_reg + 4'd1;
                end
            end
            WAIT_RD: begin
                if (cnt_reg == WAIT_LAST) begin
                    state_next = READ;
                    cnt_next   = 4'd0;
                end else begin
                    cnt_next = cnt_reg + 4'd1;
                end
            end
            READ: begin
                if (cnt_reg == READ_LAST) begin
                    state_next = GAP;
                    cnt_next   = 4'd0;
                end else begin
                    cnt_next = cnt_reg + 4'd1;
                end
            end
            GAP: begin
                if (cnt_reg == GAP_LAST) begin
                    state_next = IDLE;
                    cnt_next   = 4'd0;
                end else begin
                    cnt_next = cnt_reg + 4'd1;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = 4'd0;
            end
        endcase
    end

    // TX shifter: loaded on accept, shifted left once per SHIFT cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_shift_reg <= '0;
            rd_frame_reg <= 1'b0;
        end else if (accept) begin
            tx_shift_reg <= {cmd, cmd_data};
            rd_frame_reg <= expects_reply(cmd);
        end else if (state_reg == SHIFT) begin
            tx_shift_reg <= {tx_shift_reg[FRAME_LEN-2:0], 1'b0};
        end
    end

    // RX shifter: MISO enters at the LSB on every READ edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_shift_reg <= '0;
        end else if (state_reg == READ) begin
            rx_shift_reg <= {rx_shift_reg[RX_LEN-2:0], MISO};
        end
    end

    // Serial line drivers. START presents cmd[1] early so the slave sees
    // the read/write selector before the first SHIFT bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mosi_reg <= 1'b0;
            ss_n_reg <= 1'b1;
        end else begin
            unique case (state_reg)
                START, SHIFT: begin
                    mosi_reg <= tx_shift_reg[FRAME_LEN-1];
                    ss_n_reg <= 1'b0;
                end
                WAIT_RD, READ: begin
                    mosi_reg <= 1'b0;
                    ss_n_reg <= 1'b0;
                end
                default: begin
                    mosi_reg <= 1'b0;
                    ss_n_reg <= 1'b1;
                end
            endcase
        end
    end

    // Reply hand-off: the assembled byte is published on the first GAP
    // edge of a read-data frame, the same edge that raises SS_n.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid_reg <= 1'b0;
            rd_data_reg  <= 8'h00;
        end else begin
            rd_valid_reg <= 1'b0;
            if (state_reg == GAP && cnt_reg == 4'd0 && rd_frame_reg) begin
                rd_valid_reg <= 1'b1;
                rd_data_reg  <= rx_shift_reg;
            end
        end
    end

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: per-edge logging of each frame against
// hand-computed MOSI/SS_n/handshake timelines and a MISO reply model.
module tb_spi_master;

    localparam int unsigned TB_RD_WAIT = 1;
    localparam int unsigned TB_GAP     = 2;
    localparam int          LOG_LEN    = 40;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd = 2'b00;
    logic [7:0] cmd_data = 8'h00;
    logic       rd_valid;
    logic [7:0] rd_data;
    logic       busy;
    logic       MOSI;
    logic       SS_n;
    logic       MISO = 1'b0;

    int checks = 0;
    int errors = 0;

    // Per-edge snapshots: index k holds values seen after edge A+k.
    logic       mosi_log [LOG_LEN];
    logic       ss_log   [LOG_LEN];
    logic       rdv_log  [LOG_LEN];
    logic       rdy_log  [LOG_LEN];
    logic       busy_log [LOG_LEN];
    logic       acc_log  [LOG_LEN];
    logic [7:0] rdd_log  [LOG_LEN];

    spi_master #(
        .RD_WAIT    (TB_RD_WAIT),
        .GAP_CYCLES (TB_GAP)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd       (cmd),
        .cmd_data  (cmd_data),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .busy      (busy),
        .MOSI      (MOSI),
        .SS_n      (SS_n),
        .MISO      (MISO)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issue one command at a negedge and log ncyc edges from accept edge A.
    // With hold set, cmd_valid stays high for the whole window.
    task automatic run_frame(input logic [1:0] c, input logic [7:0] d,
                             input logic [7:0] miso_byte, input bit hold,
                             input int ncyc);
        int bit_i;
        @(negedge clk);
        check("ready_before_accept", {31'd0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1;
        cmd       = c;
        cmd_data  = d;
        @(posedge clk);
        for (int k = 0; k < ncyc; k++) begin
            @(negedge clk);
            mosi_log[k] = MOSI;
            ss_log[k]   = SS_n;
            rdv_log[k]  = rd_valid;
            rdy_log[k]  = cmd_ready;
            busy_log[k] = busy;
            rdd_log[k]  = rd_data;
            if (k == 0 && !hold) cmd_valid = 1'b0;
            acc_log[k]  = cmd_valid && cmd_ready;
            bit_i = k - 11 - int'(TB_RD_WAIT);
            MISO  = (bit_i >= 0 && bit_i <= 7) ? miso_byte[7 - bit_i] : 1'b0;
        end
        cmd_valid = 1'b0;
        MISO      = 1'b0;
        $display("txn cmd=%b data=0x%02h rd_data=0x%02h", c, d, rd_data);
    endtask

    // Compare MOSI after edges A+1..A+11 against an 11-bit expected pattern.
    task automatic check_mosi(input string name, input logic [10:0] exp_bits);
        for (int k = 1; k <= 11; k++) begin
            check($sformatf("%s_mosi_k%0d", name, k), {31'd0, mosi_log[k]},
                  {31'd0, exp_bits[11 - k]});
        end
    endtask

    // Wait for the DUT to return to IDLE; an expired budget is a failure.
    task automatic wait_idle();
        int n;
        n = 0;
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("idle_within_budget", {31'd0, cmd_ready}, 32'd1);
    endtask

    int low_cnt;
    int pulses;
    int first_acc;

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_ss_n",     {31'd0, SS_n},      32'd1);
        check("rst_mosi",     {31'd0, MOSI},      32'd0);
        check("rst_rd_valid", {31'd0, rd_valid},  32'd0);
        check("rst_rd_data",  {24'd0, rd_data},   32'h00);
        check("rst_busy",     {31'd0, busy},      32'd0);
        check("rst_ready",    {31'd0, cmd_ready}, 32'd1);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Write-addr 0x2A
        run_frame(2'b00, 8'h2A, 8'h00, 1'b0, 30);
        check_mosi("wa2a", 11'b00000101010);
        low_cnt = 0;
        pulses  = 0;
        for (int k = 0; k < 30; k++) begin
            if (!ss_log[k]) low_cnt++;
            if (rdv_log[k]) pulses++;
        end
        check("wa2a_ss_low_cycles", low_cnt, 11);
        check("wa2a_ss_k0",     {31'd0, ss_log[0]},  32'd1);
        check("wa2a_ss_k12",    {31'd0, ss_log[12]}, 32'd1);
        check("wa2a_no_rdv",    pulses, 0);
        check("wa2a_ready_k12", {31'd0, rdy_log[12]}, 32'd0);
        check("wa2a_ready_k13", {31'd0, rdy_log[13]}, 32'd1);

        // Write-data 0xFF
        run_frame(2'b01, 8'hFF, 8'h00, 1'b0, 30);
        check_mosi("wdff", 11'b00111111111);
        check("wdff_busy_k12",  {31'd0, busy_log[12]}, 32'd1);
        check("wdff_ready_k13", {31'd0, rdy_log[13]},  32'd1);

        // Read-data with the slave answering 0xA5
        run_frame(2'b11, 8'h00, 8'hA5, 1'b0, 30);
        check_mosi("rd", 11'b11100000000);
        check("rd_ss_k20",     {31'd0, ss_log[20]},  32'd0);
        check("rd_ss_k21",     {31'd0, ss_log[21]},  32'd1);
        check("rd_rdv_k20",    {31'd0, rdv_log[20]}, 32'd0);
        check("rd_rdv_k21",    {31'd0, rdv_log[21]}, 32'd1);
        check("rd_rdv_k22",    {31'd0, rdv_log[22]}, 32'd0);
        check("rd_data_k20",   {24'd0, rdd_log[20]}, 32'h00);
        check("rd_data_k21",   {24'd0, rdd_log[21]}, 32'hA5);
        check("rd_mosi_k15",   {31'd0, mosi_log[15]}, 32'd0);
        check("rd_ready_k21",  {31'd0, rdy_log[21]}, 32'd0);
        check("rd_ready_k22",  {31'd0, rdy_log[22]}, 32'd1);

        // Read-addr must not disturb the held reply byte
        run_frame(2'b10, 8'h2A, 8'h00, 1'b0, 16);
        check_mosi("ra2a", 11'b11000101010);
        check("rd_data_hold", {24'd0, rd_data}, 32'hA5);

        // Back-to-back with cmd_valid held high
        run_frame(2'b00, 8'h55, 8'h00, 1'b1, 20);
        first_acc = -1;
        for (int k = 0; k < 20; k++) begin
            if (acc_log[k] && first_acc < 0) first_acc = k + 1;
        end
        check("b2b_second_accept_edge", first_acc, 14);
        check("b2b_ss_rise_k12", {31'd0, ss_log[12]}, 32'd1);
        for (int k = 0; k <= 12; k++) begin
            check($sformatf("b2b_busy_k%0d", k), {31'd0, busy_log[k]}, 32'd1);
        end
        check("b2b_second_start_ss", {31'd0, ss_log[15]}, 32'd0);
        wait_idle();

        // Reset during SHIFT bit 5 of a read-data frame
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd       = 2'b11;
        cmd_data  = 8'hFF;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (7) @(negedge clk);
        check("mid_mosi_before", {31'd0, MOSI}, 32'd1);
        check("mid_ss_before",   {31'd0, SS_n}, 32'd0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_ss_n",    {31'd0, SS_n},    32'd1);
        check("mid_rst_mosi",    {31'd0, MOSI},    32'd0);
        check("mid_rst_rd_data", {24'd0, rd_data}, 32'h00);
        check("mid_rst_busy",    {31'd0, busy},    32'd0);
        $display("txn reset asserted mid-frame");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            if (rd_valid) pulses++;
        end
        check("mid_rst_no_rdv", pulses, 0);

        // Fresh write-addr 0x01 after reset
        run_frame(2'b00, 8'h01, 8'h00, 1'b0, 16);
        check_mosi("wa01", 11'b00000000001);
        check("wa01_ss_k11", {31'd0, ss_log[11]}, 32'd0);
        check("wa01_ss_k12", {31'd0, ss_log[12]}, 32'd1);
        check("wa01_ready_k13", {31'd0, rdy_log[13]}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog so the bench always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule
